// File: rtl/wb_regfile.sv
// Write-back register file: 2^ADDR_W x DATA_W, r0 hardwired to zero, two bypassed read ports.
// Latency: writes commit on the next edge, reads are combinational; no backpressure, WB is never stalled.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [CNT_W-1:0]  wr_count_q;
    logic [CNT_W-1:0]  wr_count_d;
    logic              commit;

    logic              rd_en   [2];
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_dat  [2];

    always_comb begin
        commit     = we && (waddr != '0);
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (commit) begin
            regs_d[waddr] = wdata;
            wr_count_d    = wr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Bypass lets decode see the value write-back commits on this same edge.
    always_comb begin
        rd_en[0]   = re1;
        rd_en[1]   = re2;
        rd_addr[0] = raddr1;
        rd_addr[1] = raddr2;
        for (int p = 0; p < 2; p++) begin
            rd_dat[p] = '0;
            if (!rst && rd_en[p] && (rd_addr[p] != '0)) begin
                if (we && (waddr == rd_addr[p])) begin
                    rd_dat[p] = wdata;
                end else begin
                    rd_dat[p] = regs_q[rd_addr[p]];
                end
            end
        end
    end

    assign rdata1   = rd_dat[0];
    assign rdata2   = rd_dat[1];
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table on the default build, hand sequences on a CNT_W=4 build.
module tb_wb_regfile;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default build
    logic        rst, we, re1, re2;
    logic [4:0]  waddr, raddr1, raddr2;
    logic [31:0] wdata, rdata1, rdata2, wr_count;

    // Narrow-counter build
    logic        rst4, we4, re4a, re4b;
    logic [4:0]  waddr4, raddr4a, raddr4b;
    logic [31:0] wdata4, rdata4a, rdata4b;
    logic [3:0]  count4;

    wb_regfile dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .wr_count(wr_count)
    );

    wb_regfile #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst4), .we(we4), .waddr(waddr4), .wdata(wdata4),
        .re1(re4a), .raddr1(raddr4a), .rdata1(rdata4a),
        .re2(re4b), .raddr2(raddr4b), .rdata2(rdata4b),
        .wr_count(count4)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        re1;
        logic [4:0]  raddr1;
        logic        re2;
        logic [4:0]  raddr2;
        logic [31:0] exp_rd1;
        logic [31:0] exp_rd2;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(logic r, logic w, logic [4:0] wa, logic [31:0] wd,
                                logic e1, logic [4:0] a1, logic e2, logic [4:0] a2,
                                logic [31:0] x1, logic [31:0] x2, logic [31:0] xc);
        vec_t v;
        v.rst = r; v.we = w; v.waddr = wa; v.wdata = wd;
        v.re1 = e1; v.raddr1 = a1; v.re2 = e2; v.raddr2 = a2;
        v.exp_rd1 = x1; v.exp_rd2 = x2; v.exp_cnt = xc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive4(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        rst4 = r; we4 = w; waddr4 = wa; wdata4 = wd;
    endtask

    initial begin
        // Vector table: inputs held for one cycle, outputs checked just before the edge.
        vecs.push_back(mk(1, 1, 5,  32'hDEADBEEF, 1, 5,  1, 5,  32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 5,  32'hDEADBEEF, 1, 5,  1, 5,  32'h0,        32'h0,        0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 5,  1, 5,  32'h0,        32'h0,        0));
        vecs.push_back(mk(0, 1, 7,  32'h12345678, 1, 7,  0, 7,  32'h12345678, 32'h0,        0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 7,  1, 7,  32'h12345678, 32'h12345678, 1));
        vecs.push_back(mk(0, 1, 9,  32'hA5A5A5A5, 1, 9,  1, 9,  32'hA5A5A5A5, 32'hA5A5A5A5, 1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 9,  1, 9,  32'hA5A5A5A5, 32'hA5A5A5A5, 2));
        vecs.push_back(mk(0, 1, 0,  32'hFFFFFFFF, 1, 0,  1, 0,  32'h0,        32'h0,        2));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 0,  1, 9,  32'h0,        32'hA5A5A5A5, 2));
        vecs.push_back(mk(0, 1, 3,  32'h55,       1, 7,  0, 3,  32'h12345678, 32'h0,        2));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 3,  0, 3,  32'h55,       32'h0,        3));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 1,  1, 3,  32'h0,        32'h55,       3));
        vecs.push_back(mk(0, 1, 3,  32'h66,       1, 3,  1, 7,  32'h66,       32'h12345678, 3));
        vecs.push_back(mk(0, 1, 7,  32'h77,       1, 3,  1, 7,  32'h66,       32'h77,       4));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 7,  1, 31, 32'h77,       32'h0,        5));
        vecs.push_back(mk(0, 1, 31, 32'hCAFEF00D, 0, 31, 1, 31, 32'h0,        32'hCAFEF00D, 5));
        vecs.push_back(mk(1, 0, 0,  32'h0,        1, 31, 1, 7,  32'h0,        32'h0,        6));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 31, 1, 7,  32'h0,        32'h0,        0));

        rst = 1; we = 0; waddr = 0; wdata = 0; re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
        rst4 = 1; we4 = 0; waddr4 = 0; wdata4 = 0; re4a = 0; raddr4a = 0; re4b = 0; raddr4b = 0;
        @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            re1 = vecs[i].re1; raddr1 = vecs[i].raddr1; re2 = vecs[i].re2; raddr2 = vecs[i].raddr2;
            #1;
            check($sformatf("vec%0d rdata1", i), rdata1, vecs[i].exp_rd1);
            check($sformatf("vec%0d rdata2", i), rdata2, vecs[i].exp_rd2);
            check($sformatf("vec%0d wr_count", i), wr_count, vecs[i].exp_cnt);
        end

        // Narrow counter: 17 commits to r1 wrap 4 bits back to 1.
        drive4(1, 0, 0, 0);
        drive4(0, 0, 0, 0);
        #1 check("wrap start", 32'(count4), 32'd0);
        for (int k = 0; k < 17; k++) begin
            drive4(0, 1, 1, 32'(k + 100));
            if (k == 15) begin
                #1 check("wrap at 15", 32'(count4), 32'd15);
            end
        end
        drive4(0, 0, 0, 0);
        re4a = 1; raddr4a = 1;
        #1;
        check("wrap count", 32'(count4), 32'd1);
        check("wrap r1 data", rdata4a, 32'd116);

        // Write to r0 does not count.
        drive4(0, 1, 0, 32'hFFFFFFFF);
        drive4(0, 0, 0, 0);
        #1 check("r0 no count", 32'(count4), 32'd1);

        // Mid-sequence reset with a write pending: cleared, write dropped, count restarts.
        for (int k = 0; k < 5; k++) drive4(0, 1, 2, 32'(k));
        drive4(1, 1, 2, 32'hBEEF);
        #1 check("rst rdata", rdata4a, 32'd0);
        drive4(0, 0, 0, 0);
        raddr4a = 2;
        #1;
        check("rst clears count", 32'(count4), 32'd0);
        check("rst drops write", rdata4a, 32'd0);
        for (int k = 0; k < 3; k++) drive4(0, 1, 2, 32'(k + 7));
        drive4(0, 0, 0, 0);
        #1;
        check("restart count", 32'(count4), 32'd3);
        check("restart r2 data", rdata4a, 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
